gs_latch_packer: RTL

GS_LATCH_PACKER -- requirements
Module: gs_latch_packer

---
 rtl/gs_latch_packer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gs_latch_packer.sv
// rtl/gs_latch_packer.sv - packs 24-bit RGB pixels into LED driver grayscale latch words
// Define GS_DOUBLE_BUF_EN for separate fill and output registers; default is a single shared register.
module gs_latch_packer #(
    parameter int NUM_LEDS    = 16,
    parameter int NUM_DRIVERS = 2,
    parameter int LATCH_SIZE  = 769
) (
    input  logic                           CLK_10M,
    input  logic                           nReset,
    input  logic [23:0]                    pix_rgb,
    input  logic                           pix_valid,
    input  logic                           pix_sof,
    output logic                           pix_ready,
    output logic [LATCH_SIZE-1:0]          gs_word,
    output logic                           gs_valid,
    input  logic                           gs_ready,
    output logic [$clog2(NUM_DRIVERS)-1:0] gs_drv_idx,
    output logic                           row_done,
    output logic                           sof_err
);

    localparam int DATA_W = LATCH_SIZE - 1;
    localparam int PW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int DW     = $clog2(NUM_DRIVERS);
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_LEDS - 1);
    localparam logic [DW-1:0] LAST_DRV = DW'(NUM_DRIVERS - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [DW-1:0]     drv_cnt_q, drv_cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DW-1:0]     idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              row_done_q, row_done_d;
    logic              sof_err_q, sof_err_d;
`ifdef GS_DOUBLE_BUF_EN
    logic [DATA_W-1:0] out_q, out_d;
    logic [DW-1:0]     pend_q, pend_d;
`endif

    logic              accept;
    logic              take;
    logic              restart;
    logic              complete;
    logic [PW-1:0]     cur_pix;
    logic [DW-1:0]     cur_drv;
    logic [47:0]       pix48;
    logic [DATA_W-1:0] packed_word;

    assign take     = valid_q & gs_ready;
    assign accept   = pix_valid & pix_ready;
    // A sof anywhere but the very start of a row restarts packing at LED 0 of driver 0.
    assign restart  = accept & pix_sof & ((pix_cnt_q != '0) | (drv_cnt_q != '0));
    assign cur_pix  = restart ? '0 : pix_cnt_q;
    assign cur_drv  = restart ? '0 : drv_cnt_q;
    assign complete = accept & (cur_pix == LAST_PIX);
    assign pix48    = {pix_rgb[7:0],   pix_rgb[7:0],
                       pix_rgb[15:8],  pix_rgb[15:8],
                       pix_rgb[23:16], pix_rgb[23:16]};

    always_comb begin
        packed_word = fill_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (cur_pix == PW'(i)) begin
                packed_word[48*i +: 48] = pix48;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        drv_cnt_d  = drv_cnt_q;
        fill_d     = fill_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        sof_err_d  = sof_err_q | restart;
        row_done_d = take & (idx_q == LAST_DRV);
`ifdef GS_DOUBLE_BUF_EN
        out_d      = out_q;
        pend_d     = pend_q;
        pix_ready  = run_q & (state_q == FILL);
`else
        pix_ready  = run_q & (state_q == FILL) & ~valid_q;
`endif

        if (take) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            fill_d    = packed_word;
            pix_cnt_d = complete ? '0 : cur_pix + 1'b1;
            if (complete) begin
                drv_cnt_d = (cur_drv == LAST_DRV) ? '0 : cur_drv + 1'b1;
            end else begin
                drv_cnt_d = cur_drv;
            end
        end

`ifdef GS_DOUBLE_BUF_EN
        if (state_q == FILL) begin
            if (complete) begin
                // Hand the word straight over when the output slot is free or emptying now.
                if (!valid_q || take) begin
                    out_d   = packed_word;
                    idx_d   = cur_drv;
                    valid_d = 1'b1;
                end else begin
                    pend_d  = cur_drv;
                    state_d = FULL;
                end
            end
        end else begin
            if (take) begin
                out_d   = fill_q;
                idx_d   = pend_q;
                valid_d = 1'b1;
                state_d = FILL;
            end
        end
`else
        if (complete) begin
            idx_d   = cur_drv;
            valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK_10M) begin
        if (!nReset) begin
            state_q    <= FILL;
            run_q      <= 1'b0;
            pix_cnt_q  <= '0;
            drv_cnt_q  <= '0;
            fill_q     <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            row_done_q <= 1'b0;
            sof_err_q  <= 1'b0;
`ifdef GS_DOUBLE_BUF_EN
            out_q      <= '0;
            pend_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            pix_cnt_q  <= pix_cnt_d;
            drv_cnt_q  <= drv_cnt_d;
            fill_q     <= fill_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            row_done_q <= row_done_d;
            sof_err_q  <= sof_err_d;
`ifdef GS_DOUBLE_BUF_EN
            out_q      <= out_d;
            pend_q     <= pend_d;
`endif
        end
    end

`ifdef GS_DOUBLE_BUF_EN
    assign gs_word = {1'b0, out_q};
`else
    assign gs_word = {1'b0, fill_q};
`endif
    assign gs_valid   = valid_q;
    assign gs_drv_idx = idx_q;
    assign row_done   = row_done_q;
    assign sof_err    = sof_err_q;

endmodule
